// File: rtl/crc_serial_codec.sv
// Bit-serial CRC generator/checker, MSB first, with valid/ready handshakes on both sides.
// Generate mode appends the computed CRC; check mode reports the syndrome against crc_in.
module crc_serial_codec #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned CRC_W  = 5,
    parameter logic [31:0] POLY   = 32'h15,
    parameter logic [31:0] INIT   = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic [DATA_W-1:0]         data_in,
    input  logic [CRC_W-1:0]          crc_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_mode,
    output logic [DATA_W+CRC_W-1:0]   data_out,
    output logic [CRC_W-1:0]          crc_out,
    output logic                      crc_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CRC_W-1:0] POLY_C = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                    state_q, state_d;
    logic [DATA_W-1:0]         data_q, data_d;
    logic [DATA_W-1:0]         shift_q, shift_d;
    logic [CRC_W-1:0]          crc_in_q, crc_in_d;
    logic [CRC_W-1:0]          crc_q, crc_d;
    logic                      mode_q, mode_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      out_mode_q, out_mode_d;
    logic [DATA_W+CRC_W-1:0]   data_out_q, data_out_d;
    logic [CRC_W-1:0]          crc_out_q, crc_out_d;
    logic                      crc_err_q, crc_err_d;

    logic                      fb;
    logic [CRC_W-1:0]          crc_step;

    // Augmented-division step; the shift by one also covers CRC_W == 1, where it yields fb.
    always_comb begin
        fb       = crc_q[CRC_W-1] ^ shift_q[DATA_W-1];
        crc_step = (crc_q << 1) ^ (fb ? POLY_C : '0);
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        shift_d    = shift_q;
        crc_in_d   = crc_in_q;
        crc_d      = crc_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        out_mode_d = out_mode_q;
        data_out_d = data_out_q;
        crc_out_d  = crc_out_q;
        crc_err_d  = crc_err_q;

        // Abort keeps the last presented result registers untouched.
        if (clr) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_d   = data_in;
                        shift_d  = data_in;
                        crc_in_d = crc_in;
                        mode_d   = mode;
                        crc_d    = INIT_C;
                        cnt_d    = CNT_W'(DATA_W);
                        state_d  = StCalc;
                    end
                end
                StCalc: begin
                    crc_d   = crc_step;
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        out_mode_d = mode_q;
                        crc_out_d  = mode_q ? (crc_step ^ crc_in_q) : crc_step;
                        data_out_d = {data_q, (mode_q ? crc_in_q : crc_step)};
                        crc_err_d  = mode_q && (crc_step != crc_in_q);
                        state_d    = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            data_q     <= '0;
            shift_q    <= '0;
            crc_in_q   <= '0;
            crc_q      <= '0;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            out_mode_q <= 1'b0;
            data_out_q <= '0;
            crc_out_q  <= '0;
            crc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            crc_in_q   <= crc_in_d;
            crc_q      <= crc_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            out_mode_q <= out_mode_d;
            data_out_q <= data_out_d;
            crc_out_q  <= crc_out_d;
            crc_err_q  <= crc_err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_mode  = out_mode_q;
    assign data_out  = data_out_q;
    assign crc_out   = crc_out_q;
    assign crc_err   = crc_err_q;

endmodule
